// File: rtl/div_pkg.sv
// Shared types, widths and result helpers for the radix-2 restoring divider.
package div_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    if (neg) begin
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Result for divide-by-zero or signed overflow; rem_sel picks remainder over quotient.
  function automatic logic [XLEN-1:0] special_result(input logic rem_sel, input logic div_zero,
                                                     input logic [XLEN-1:0] dividend);
    if (div_zero) begin
      return rem_sel ? dividend : ALL_ONES;
    end else begin
      return rem_sel ? {XLEN{1'b0}} : MIN_INT;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_bit,
  output logic [XLEN-1:0] o_rem,
  output logic            o_q
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  // A borrow out of the top bit means the shifted remainder was below the divisor.
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_q     = ~w_diff[XLEN];
  assign o_rem   = o_q ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit with valid/ready handshakes on both sides.
// Build option: DIV_EARLY_OUT_EN finishes divide-by-zero and signed overflow right after accept.
module div_unit
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  div_state_e       r_state, w_state_fsm, w_state_nxt;
  logic             r_in_ready, r_out_valid, r_busy;
  logic [XLEN-1:0]  r_result, r_rem, r_quot, r_divisor, r_rs1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rem_sel, r_q_neg, r_r_neg, r_div_zero, r_ovf;

  logic             w_accept, w_signed, w_in_zero, w_in_ovf, w_step_q;
  logic [XLEN-1:0]  w_step_rem, w_quot_nxt, w_final;

  assign w_signed  = ~op[0];
  assign w_in_zero = (rs2 == {XLEN{1'b0}});
  assign w_in_ovf  = w_signed && (rs1 == MIN_INT) && (rs2 == ALL_ONES);
  assign w_accept  = (r_state == IDLE) && in_valid && !flush;

  // r_quot starts as the dividend magnitude; its MSB feeds each step and quotient bits enter at the LSB.
  div_step u_step (
    .i_rem     (r_rem),
    .i_divisor (r_divisor),
    .i_bit     (r_quot[XLEN-1]),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );
  assign w_quot_nxt = {r_quot[XLEN-2:0], w_step_q};

  // Sign-corrected result of the final step, with special cases overriding.
  always_comb begin
    w_final = {XLEN{1'b0}};
    if (r_div_zero || r_ovf) begin
      w_final = special_result(r_rem_sel, r_div_zero, r_rs1);
    end else if (r_rem_sel) begin
      w_final = cond_neg(w_step_rem, r_r_neg);
    end else begin
      w_final = cond_neg(w_quot_nxt, r_q_neg);
    end
  end

  // Next-state logic; flush wins over accept and the result handshake.
  always_comb begin
    w_state_fsm = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef DIV_EARLY_OUT_EN
          w_state_fsm = (w_in_zero || w_in_ovf) ? DONE : CALC;
`else
          w_state_fsm = CALC;
`endif
        end else begin
          w_state_fsm = IDLE;
        end
      end
      CALC: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_fsm = DONE;
        end else begin
          w_state_fsm = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_fsm = IDLE;
        end else begin
          w_state_fsm = DONE;
        end
      end
      default: w_state_fsm = IDLE;
    endcase
    w_state_nxt = flush ? IDLE : w_state_fsm;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= {XLEN{1'b0}};
      r_rem       <= {XLEN{1'b0}};
      r_quot      <= {XLEN{1'b0}};
      r_divisor   <= {XLEN{1'b0}};
      r_rs1       <= {XLEN{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_rem_sel   <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_div_zero  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
      if (w_accept) begin
        r_rem      <= {XLEN{1'b0}};
        r_quot     <= cond_neg(rs1, w_signed & rs1[XLEN-1]);
        r_divisor  <= cond_neg(rs2, w_signed & rs2[XLEN-1]);
        r_rs1      <= rs1;
        r_cnt      <= CNT_W'(XLEN-1);
        r_rem_sel  <= op[1];
        r_q_neg    <= w_signed & (rs1[XLEN-1] ^ rs2[XLEN-1]);
        r_r_neg    <= w_signed & rs1[XLEN-1];
        r_div_zero <= w_in_zero;
        r_ovf      <= w_in_ovf;
`ifdef DIV_EARLY_OUT_EN
        if (w_in_zero || w_in_ovf) begin
          r_result <= special_result(op[1], w_in_zero, rs1);
        end else begin
          r_result <= r_result;
        end
`endif
      end else if (r_state == CALC) begin
        r_rem  <= w_step_rem;
        r_quot <= w_quot_nxt;
        if (r_cnt == {CNT_W{1'b0}}) begin
          r_result <= w_final;
        end else begin
          r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;

endmodule
